// File: rtl/vector_merge_unit_pipe.sv
// rtl/vector_merge_unit_pipe.sv - elastic vmerge/vmv execution unit with configurable pipeline depth
module vector_merge_unit_pipe #(
  parameter int VLEN       = 128,
  parameter int NUM_STAGES = 2,
  parameter int ELEN       = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [1:0]                 op_mode,
  input  logic [1:0]                 sew,
  input  logic [$clog2(VLEN/8):0]    vl,
  input  logic                       tail_agn,
  input  logic [ELEN-1:0]            scalar,
  input  logic [VLEN-1:0]            vs2,
  input  logic [VLEN-1:0]            vs1,
  input  logic [VLEN-1:0]            v0,
  input  logic [VLEN-1:0]            vd_old,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [VLEN-1:0]            vd,
  output logic                       illegal_o
);

  localparam int NBYTES = VLEN / 8;
  localparam int VLW    = $clog2(VLEN / 8) + 1;

  // Only the low NBYTES mask bits can govern an element (e8 has the most elements).
  logic unused_v0;
  assign unused_v0 = ^v0[VLEN-1:NBYTES];

  logic [VLEN-1:0] comp_vd;
  logic            comp_ill;

  assign comp_ill = (op_mode == 2'b11);

  // The result is built byte by byte: each byte finds its owning element for the
  // current SEW, so one datapath serves all four element widths.
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    logic       mask_bit;
    logic       body;
    logic [7:0] sc_byte;
    logic [7:0] res_byte;

    // Resolve owning element: its mask bit, body/tail status and matching scalar byte
    always_comb begin
      mask_bit = v0[b];
      body     = (vl > VLW'(b));
      sc_byte  = scalar[7:0];
      case (sew)
        2'b01: begin
          mask_bit = v0[b/2];
          body     = (vl > VLW'(b/2));
          sc_byte  = scalar[(b%2)*8 +: 8];
        end
        2'b10: begin
          mask_bit = v0[b/4];
          body     = (vl > VLW'(b/4));
          sc_byte  = scalar[(b%4)*8 +: 8];
        end
        2'b11: begin
          mask_bit = v0[b/8];
          body     = (vl > VLW'(b/8));
          sc_byte  = scalar[(b%8)*8 +: 8];
        end
        default: ;
      endcase
    end

    // Operation select, then tail override (illegal ops pass vd_old through untouched)
    always_comb begin
      case (op_mode)
        2'b00:   res_byte = mask_bit ? vs1[b*8 +: 8] : vs2[b*8 +: 8];
        2'b01:   res_byte = mask_bit ? sc_byte : vs2[b*8 +: 8];
        2'b10:   res_byte = vs1[b*8 +: 8];
        default: res_byte = vd_old[b*8 +: 8];
      endcase
      if (op_mode != 2'b11 && !body) begin
        res_byte = tail_agn ? 8'hFF : vd_old[b*8 +: 8];
      end
    end

    assign comp_vd[b*8 +: 8] = res_byte;
  end

  logic [NUM_STAGES-1:0]           stg_valid;
  logic [NUM_STAGES-1:0]           stg_load;
  logic [NUM_STAGES-1:0]           stg_ill;
  logic [NUM_STAGES-1:0][VLEN-1:0] stg_vd;

  // Each stage advances when it is empty or the stage after it advances; this lets
  // bubbles collapse under back-pressure while full stages hold.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic            valid_q, valid_d;
    logic            ill_q, ill_d;
    logic [VLEN-1:0] vd_q, vd_d;
    logic            in_valid, in_ill;
    logic [VLEN-1:0] in_vd;

    if (k == 0) begin : g_src
      assign in_valid = valid_i;
      assign in_ill   = comp_ill;
      assign in_vd    = comp_vd;
    end else begin : g_src
      assign in_valid = stg_valid[k-1];
      assign in_ill   = stg_ill[k-1];
      assign in_vd    = stg_vd[k-1];
    end

    if (k == NUM_STAGES - 1) begin : g_load
      assign stg_load[k] = !valid_q || ready_i;
    end else begin : g_load
      assign stg_load[k] = !valid_q || stg_load[k+1];
    end

    // Take upstream contents when advancing; payload is only captured for a real op
    always_comb begin
      valid_d = valid_q;
      ill_d   = ill_q;
      vd_d    = vd_q;
      if (stg_load[k]) begin
        valid_d = in_valid;
        if (in_valid) begin
          ill_d = in_ill;
          vd_d  = in_vd;
        end
      end
    end

    // Stage register; reset empties the stage and clears its payload
    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= 1'b0;
        ill_q   <= 1'b0;
        vd_q    <= '0;
      end else begin
        valid_q <= valid_d;
        ill_q   <= ill_d;
        vd_q    <= vd_d;
      end
    end

    assign stg_valid[k] = valid_q;
    assign stg_ill[k]   = ill_q;
    assign stg_vd[k]    = vd_q;
  end

  assign ready_o   = stg_load[0];
  assign valid_o   = stg_valid[NUM_STAGES-1];
  assign illegal_o = stg_ill[NUM_STAGES-1];
  assign vd        = stg_vd[NUM_STAGES-1];

endmodule

// File: tb/tb_vector_merge_unit_pipe.sv
// tb/tb_vector_merge_unit_pipe.sv - self-checking bench for vector_merge_unit_pipe
module tb_vector_merge_unit_pipe;

  localparam int VLEN       = 128;
  localparam int NUM_STAGES = 2;
  localparam int ELEN       = 64;
  localparam int VLW        = $clog2(VLEN/8) + 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            valid_i, ready_o, valid_o, ready_i, illegal_o, tail_agn;
  logic [1:0]      op_mode, sew;
  logic [VLW-1:0]  vl;
  logic [ELEN-1:0] scalar;
  logic [VLEN-1:0] vs2, vs1, v0, vd_old, vd;

  always #5 clock = ~clock;

  vector_merge_unit_pipe #(.VLEN(VLEN), .NUM_STAGES(NUM_STAGES), .ELEN(ELEN)) dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .op_mode(op_mode), .sew(sew), .vl(vl), .tail_agn(tail_agn), .scalar(scalar),
    .vs2(vs2), .vs1(vs1), .v0(v0), .vd_old(vd_old),
    .valid_o(valid_o), .ready_i(ready_i), .vd(vd), .illegal_o(illegal_o)
  );

  typedef struct {
    logic [1:0]      op;
    logic [1:0]      sew;
    logic [VLW-1:0]  vl;
    logic            tagn;
    logic [ELEN-1:0] scalar;
    logic [VLEN-1:0] vs2, vs1, v0, vd_old;
    logic [VLEN-1:0] exp_vd;
    logic            exp_ill;
  } vec_t;

  typedef struct packed {
    logic [VLEN-1:0] vd;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Element-wise reference: walk every bit, find its element, apply the op rules.
  function automatic logic [VLEN-1:0] model(input vec_t v);
    logic [VLEN-1:0] r;
    int w, n, vle, e, p;
    w   = 8 << v.sew;
    n   = VLEN / w;
    vle = (int'(v.vl) < n) ? int'(v.vl) : n;
    for (int j = 0; j < VLEN; j++) begin
      e = j / w;
      p = j % w;
      if (v.op == 2'b11)   r[j] = v.vd_old[j];
      else if (e >= vle)   r[j] = v.tagn ? 1'b1 : v.vd_old[j];
      else if (v.op == 2'b00) r[j] = v.v0[e] ? v.vs1[j] : v.vs2[j];
      else if (v.op == 2'b01) r[j] = v.v0[e] ? v.scalar[p] : v.vs2[j];
      else                 r[j] = v.vs1[j];
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] s, input logic [VLW-1:0] l,
                              input logic tg, input logic [ELEN-1:0] sc,
                              input logic [VLEN-1:0] a2, input logic [VLEN-1:0] a1,
                              input logic [VLEN-1:0] m, input logic [VLEN-1:0] old,
                              input logic [VLEN-1:0] ev, input logic ei);
    vec_t v;
    v.op = op; v.sew = s; v.vl = l; v.tagn = tg; v.scalar = sc;
    v.vs2 = a2; v.vs1 = a1; v.v0 = m; v.vd_old = old;
    v.exp_vd = ev; v.exp_ill = ei;
    return v;
  endfunction

  function automatic vec_t mk_rand();
    vec_t v;
    v.op     = 2'($urandom_range(0, 3));
    v.sew    = 2'($urandom_range(0, 3));
    v.vl     = VLW'($urandom_range(0, 20));
    v.tagn   = 1'($urandom_range(0, 1));
    v.scalar = {$urandom, $urandom};
    v.vs2    = {$urandom, $urandom, $urandom, $urandom};
    v.vs1    = {$urandom, $urandom, $urandom, $urandom};
    v.v0     = {$urandom, $urandom, $urandom, $urandom};
    v.vd_old = {$urandom, $urandom, $urandom, $urandom};
    v.exp_vd  = model(v);
    v.exp_ill = (v.op == 2'b11);
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic vld);
    valid_i  = vld;
    op_mode  = v.op;
    sew      = v.sew;
    vl       = v.vl;
    tail_agn = v.tagn;
    scalar   = v.scalar;
    vs2      = v.vs2;
    vs1      = v.vs1;
    v0       = v.v0;
    vd_old   = v.vd_old;
    cur_exp.vd  = v.exp_vd;
    cur_exp.ill = v.exp_ill;
  endtask

  // One clock: sample at the falling edge, score emits/accepts, then advance past the rising edge.
  task automatic step(output bit acc);
    exp_t e;
    acc = 1'b0;
    @(negedge clock);
    if (!reset) begin
      chk("ready_o", VLEN'(ready_o), VLEN'(!(sb.size() == NUM_STAGES && !ready_i)));
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("spurious_valid_o", VLEN'(valid_o), VLEN'(1'b0));
        end else begin
          e = sb.pop_front();
          pops++;
          chk("vd", vd, e.vd);
          chk("illegal_o", VLEN'(illegal_o), VLEN'(e.ill));
        end
      end
      if (valid_i && ready_o) begin
        acc = 1'b1;
        sb.push_back(cur_exp);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit   acc;
    int   lat, n, idx, cyc, p0;
    vec_t cur;

    tbl[0] = mk(2'd0, 2'd0, 5'd16, 1'b0, 64'h0, {16{8'h22}}, {16{8'h11}}, 128'hAAAA,
                {16{8'h77}}, {8{16'h1122}}, 1'b0);
    tbl[1] = mk(2'd1, 2'd2, 5'd2, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF, '0, {16{8'h33}}, 128'h1,
                {4{32'h5}}, {32'h5, 32'h5, 32'h0, 32'hDEADBEEF}, 1'b0);
    tbl[2] = mk(2'd2, 2'd3, 5'd9, 1'b1, 64'h0, {8{16'hBEEF}},
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0, {4{32'h0BAD_F00D}},
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
    tbl[3] = mk(2'd2, 2'd3, 5'd0, 1'b1, 64'h0, {8{16'hBEEF}}, {8{16'h1234}}, '0,
                {4{32'h0BAD_F00D}}, {VLEN{1'b1}}, 1'b0);
    tbl[4] = mk(2'd3, 2'd0, 5'd16, 1'b1, 64'h1234, {16{8'h22}}, {16{8'h11}}, {VLEN{1'b1}},
                128'hCAFE_0000_1111_2222_3333_4444_5555_6666,
                128'hCAFE_0000_1111_2222_3333_4444_5555_6666, 1'b1);
    tbl[5] = mk(2'd0, 2'd1, 5'd5, 1'b1, 64'h0, {8{16'h5555}}, {8{16'hAAAA}}, 128'h13, '0,
                {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hAAAA, 16'h5555, 16'h5555, 16'hAAAA, 16'hAAAA}, 1'b0);
    tbl[6] = mk(2'd1, 2'd0, 5'd20, 1'b1, 64'h1111_2222_3333_447E, '0, {16{8'h99}},
                {{112{1'b1}}, 16'h000F}, {16{8'h44}}, 128'h7E7E7E7E, 1'b0);
    tbl[7] = mk(2'd2, 2'd0, 5'd3, 1'b0, 64'h0, '0, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100,
                '0, {16{8'h99}}, 128'h9999_9999_9999_9999_9999_9999_9902_0100, 1'b0);
    for (int i = 8; i < 14; i++) tbl[i] = mk_rand();

    // Reset state
    reset   = 1'b1;
    ready_i = 1'b0;
    drive(tbl[0], 1'b0);
    repeat (2) step(acc);
    chk("reset_valid_o", VLEN'(valid_o), '0);
    chk("reset_vd", vd, '0);
    chk("reset_illegal_o", VLEN'(illegal_o), '0);
    reset = 1'b0;
    #1;
    chk("reset_ready_o", VLEN'(ready_o), VLEN'(1'b1));

    // Latency of a single op with ready_i held high
    ready_i = 1'b1;
    drive(tbl[0], 1'b1);
    step(acc);
    drive(tbl[0], 1'b0);
    lat = 1;
    while (!valid_o && lat < 20) begin
      step(acc);
      lat++;
    end
    chk("latency", VLEN'(lat), VLEN'(NUM_STAGES));

    // Table streamed back to back (illegal row 4 sits between two legal ops)
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i], 1'b1);
      step(acc);
    end
    drive(tbl[0], 1'b0);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step(acc);
      n++;
    end
    chk("table_drain", VLEN'(sb.size()), '0);

    // Back-pressure: ready_i pattern 1,0,0 repeating, 8 ops in order
    cur = mk_rand();
    idx = 0;
    cyc = 0;
    p0  = pops;
    while ((idx < 8 || sb.size() != 0) && cyc < 200) begin
      ready_i = (cyc % 3 == 0);
      drive(cur, idx < 8);
      step(acc);
      if (acc) begin
        idx++;
        cur = mk_rand();
      end
      cyc++;
    end
    chk("bp_result_count", VLEN'(pops - p0), VLEN'(8));
    chk("bp_accept_count", VLEN'(idx), VLEN'(8));

    // Reset with two ops in flight drops them
    ready_i = 1'b0;
    drive(mk_rand(), 1'b1);
    step(acc);
    drive(mk_rand(), 1'b1);
    step(acc);
    chk("inflight_before_reset", VLEN'(sb.size()), VLEN'(2));
    drive(tbl[0], 1'b0);
    reset = 1'b1;
    step(acc);
    chk("midreset_valid_o", VLEN'(valid_o), '0);
    chk("midreset_vd", vd, '0);
    sb.delete();
    reset   = 1'b0;
    ready_i = 1'b1;
    repeat (6) step(acc);
    chk("post_reset_valid_o", VLEN'(valid_o), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
